ejection_sink: RTL and testbench



---
 rtl/noc_pkg.sv | 43 ++++
 rtl/credit_delay_line.sv | 44 ++++
 rtl/ejection_sink.sv | 196 +++++++++++++++++++
 tb/tb_ejection_sink.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// noc_pkg: shared constants for the ejection sink and its credit delay line.
//   - widths of VC index, router ID, cycle stamps and counters
//   - credit delay line depth and tap width
//   - error codes reported by the sink
//   - per-VC packet framing state encoding
//   - delay_to_tap(): maps the configured credit delay onto a delay-line tap
package noc_pkg;

  localparam int NUM_VC           = 4;
  localparam int VC_BITS          = 2;
  localparam int RID_BITS         = 6;
  localparam int CYC_BITS         = 16;
  localparam int CNT_BITS         = 16;
  localparam int MAX_CREDIT_DELAY = 8;
  localparam int CD_BITS          = 4;
  localparam int TAP_BITS         = $clog2(MAX_CREDIT_DELAY);

  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_HEAD_BUSY = 2'd1;
  localparam logic [1:0] ERR_ORPHAN    = 2'd2;
  localparam logic [1:0] ERR_DST       = 2'd3;

  typedef enum logic {
    VC_IDLE = 1'b0,
    VC_BUSY = 1'b1
  } vc_state_e;

  // A delay of 0 behaves as 1 and anything above the line depth is clamped,
  // so the returned tap is always a valid stage index (delay - 1).
  function automatic logic [TAP_BITS-1:0] delay_to_tap(input logic [CD_BITS-1:0] d);
    logic [CD_BITS-1:0] eff;
    if (d == '0) begin
      eff = CD_BITS'(1);
    end else if (d > CD_BITS'(MAX_CREDIT_DELAY)) begin
      eff = CD_BITS'(MAX_CREDIT_DELAY);
    end else begin
      eff = d;
    end
    eff = eff - CD_BITS'(1);
    return eff[TAP_BITS-1:0];
  endfunction

endpackage

// File: rtl/credit_delay_line.sv
// credit_delay_line: shift register of {valid, vc} entries with a selectable
// output tap. An entry written in cycle t appears at the output in cycle
// t + tap_i + 1.
//   clk        system clock
//   clr_i      synchronous clear of every stage
//   in_valid_i credit to schedule this cycle
//   in_vc_i    VC of the scheduled credit
//   tap_i      stage index driving the output
//   out_valid_o credit strobe
//   out_vc_o   credited VC (0 when no credit)
module credit_delay_line
  import noc_pkg::*;
(
  input  logic                clk,
  input  logic                clr_i,
  input  logic                in_valid_i,
  input  logic [VC_BITS-1:0]  in_vc_i,
  input  logic [TAP_BITS-1:0] tap_i,
  output logic                out_valid_o,
  output logic [VC_BITS-1:0]  out_vc_o
);

  logic [MAX_CREDIT_DELAY-1:0] valid_q;
  logic [VC_BITS-1:0]          vc_q [MAX_CREDIT_DELAY];

  always_ff @(posedge clk) begin
    if (clr_i) begin
      valid_q <= '0;
      for (int i = 0; i < MAX_CREDIT_DELAY; i++) begin
        vc_q[i] <= '0;
      end
    end else begin
      valid_q <= {valid_q[MAX_CREDIT_DELAY-2:0], in_valid_i};
      vc_q[0] <= in_vc_i;
      for (int i = 1; i < MAX_CREDIT_DELAY; i++) begin
        vc_q[i] <= vc_q[i-1];
      end
    end
  end

  assign out_valid_o = valid_q[tap_i];
  assign out_vc_o    = valid_q[tap_i] ? vc_q[tap_i] : '0;

endmodule

// File: rtl/ejection_sink.sv
// ejection_sink: terminal consumer on a router's ejection port. Accepts one
// flit per cycle without backpressure, frames packets per VC, checks the
// destination against the local router ID, keeps packet/flit/latency
// statistics and returns a credit per flit after the configured delay.
//   clk, rst            clock, synchronous active-high reset
//   init                clear statistics/errors/credits and latch cfg_*
//   cfg_*               router ID, credit delay, expected packet count
//   in_cycle            current network cycle (latency reference)
//   flit_*              ejected flit: valid, vc, head, tail, dst, stamp
//   cr_valid, cr_vc     credit return
//   pkt_count, flit_count, lat_sum, lat_max   statistics
//   err, err_code       sticky error flag and first error code
//   done                expected packet count reached (sticky)
//
// Per-VC framing state:
//   state   | meaning
//   VC_IDLE | no packet open; next flit must be a head
//   VC_BUSY | head seen, stamp stored, waiting for body/tail
module ejection_sink
  import noc_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init,
  input  logic [RID_BITS-1:0]   cfg_router_id,
  input  logic [CD_BITS-1:0]    cfg_credit_delay,
  input  logic [CNT_BITS-1:0]   cfg_expected_pkts,
  input  logic [CYC_BITS-1:0]   in_cycle,
  input  logic                  flit_valid,
  input  logic [VC_BITS-1:0]    flit_vc,
  input  logic                  flit_head,
  input  logic                  flit_tail,
  input  logic [RID_BITS-1:0]   flit_dst,
  input  logic [CYC_BITS-1:0]   flit_stamp,
  output logic                  cr_valid,
  output logic [VC_BITS-1:0]    cr_vc,
  output logic [CNT_BITS-1:0]   pkt_count,
  output logic [CNT_BITS-1:0]   flit_count,
  output logic [2*CYC_BITS-1:0] lat_sum,
  output logic [CYC_BITS-1:0]   lat_max,
  output logic                  err,
  output logic [1:0]            err_code,
  output logic                  done
);

  logic [RID_BITS-1:0]   rid_q;
  logic [TAP_BITS-1:0]   tap_q;
  logic [CNT_BITS-1:0]   exp_q;

  vc_state_e             state_q [NUM_VC];
  vc_state_e             state_d [NUM_VC];
  logic [CYC_BITS-1:0]   stamp_q [NUM_VC];
  logic [CYC_BITS-1:0]   stamp_d [NUM_VC];

  logic [CNT_BITS-1:0]   pkt_q, pkt_d;
  logic [CNT_BITS-1:0]   flit_q, flit_d;
  logic [2*CYC_BITS-1:0] lsum_q, lsum_d;
  logic [CYC_BITS-1:0]   lmax_q, lmax_d;
  logic                  err_q, err_d;
  logic [1:0]            code_q, code_d;
  logic                  done_q, done_d;

  logic                  accept;
  logic                  complete;
  logic [CYC_BITS-1:0]   lat;
  logic [1:0]            new_err;
  logic [2*CYC_BITS:0]   lsum_wide;

  // A flit presented together with init is dropped.
  assign accept = flit_valid & ~init;

  always_comb begin
    state_d   = state_q;
    stamp_d   = stamp_q;
    pkt_d     = pkt_q;
    flit_d    = flit_q;
    lsum_d    = lsum_q;
    lmax_d    = lmax_q;
    err_d     = err_q;
    code_d    = code_q;
    complete  = 1'b0;
    lat       = '0;
    new_err   = ERR_NONE;
    lsum_wide = '0;

    if (accept) begin
      flit_d = flit_q + CNT_BITS'(1);
      if (flit_head) begin
        // Head-on-busy outranks a destination mismatch on the same flit.
        if (state_q[flit_vc] == VC_BUSY) begin
          new_err = ERR_HEAD_BUSY;
        end else if (flit_dst != rid_q) begin
          new_err = ERR_DST;
        end
        if (flit_tail) begin
          complete         = 1'b1;
          lat              = in_cycle - flit_stamp;
          state_d[flit_vc] = VC_IDLE;
        end else begin
          stamp_d[flit_vc] = flit_stamp;
          state_d[flit_vc] = VC_BUSY;
        end
      end else if (state_q[flit_vc] == VC_IDLE) begin
        new_err = ERR_ORPHAN;
      end else if (flit_tail) begin
        complete         = 1'b1;
        lat              = in_cycle - stamp_q[flit_vc];
        state_d[flit_vc] = VC_IDLE;
      end
    end

    if (complete) begin
      pkt_d     = pkt_q + CNT_BITS'(1);
      lsum_wide = {1'b0, lsum_q} + {{(CYC_BITS+1){1'b0}}, lat};
      lsum_d    = lsum_wide[2*CYC_BITS] ? '1 : lsum_wide[2*CYC_BITS-1:0];
      if (lat > lmax_q) begin
        lmax_d = lat;
      end
    end

    if (new_err != ERR_NONE) begin
      err_d = 1'b1;
      if (!err_q) begin
        code_d = new_err;
      end
    end

    // Looks at the next count so done rises in the same cycle as pkt_count.
    done_d = done_q | ((exp_q != '0) && (pkt_d == exp_q));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rid_q  <= '0;
      tap_q  <= '0;
      exp_q  <= '0;
      pkt_q  <= '0;
      flit_q <= '0;
      lsum_q <= '0;
      lmax_q <= '0;
      err_q  <= 1'b0;
      code_q <= ERR_NONE;
      done_q <= 1'b0;
      for (int i = 0; i < NUM_VC; i++) begin
        state_q[i] <= VC_IDLE;
        stamp_q[i] <= '0;
      end
    end else if (init) begin
      rid_q  <= cfg_router_id;
      tap_q  <= delay_to_tap(cfg_credit_delay);
      exp_q  <= cfg_expected_pkts;
      pkt_q  <= '0;
      flit_q <= '0;
      lsum_q <= '0;
      lmax_q <= '0;
      err_q  <= 1'b0;
      code_q <= ERR_NONE;
      done_q <= 1'b0;
      for (int i = 0; i < NUM_VC; i++) begin
        state_q[i] <= VC_IDLE;
        stamp_q[i] <= '0;
      end
    end else begin
      pkt_q  <= pkt_d;
      flit_q <= flit_d;
      lsum_q <= lsum_d;
      lmax_q <= lmax_d;
      err_q  <= err_d;
      code_q <= code_d;
      done_q <= done_d;
      for (int i = 0; i < NUM_VC; i++) begin
        state_q[i] <= state_d[i];
        stamp_q[i] <= stamp_d[i];
      end
    end
  end

  credit_delay_line u_credit_delay_line (
    .clk         (clk),
    .clr_i       (rst | init),
    .in_valid_i  (accept),
    .in_vc_i     (flit_vc),
    .tap_i       (tap_q),
    .out_valid_o (cr_valid),
    .out_vc_o    (cr_vc)
  );

  assign pkt_count  = pkt_q;
  assign flit_count = flit_q;
  assign lat_sum    = lsum_q;
  assign lat_max    = lmax_q;
  assign err        = err_q;
  assign err_code   = code_q;
  assign done       = done_q;

endmodule

// File: tb/tb_ejection_sink.sv
module tb_ejection_sink;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        init = 1'b0;
  logic [5:0]  cfg_router_id = '0;
  logic [3:0]  cfg_credit_delay = '0;
  logic [15:0] cfg_expected_pkts = '0;
  logic [15:0] in_cycle = '0;
  logic        flit_valid = 1'b0;
  logic [1:0]  flit_vc = '0;
  logic        flit_head = 1'b0;
  logic        flit_tail = 1'b0;
  logic [5:0]  flit_dst = '0;
  logic [15:0] flit_stamp = '0;
  logic        cr_valid;
  logic [1:0]  cr_vc;
  logic [15:0] pkt_count;
  logic [15:0] flit_count;
  logic [31:0] lat_sum;
  logic [15:0] lat_max;
  logic        err;
  logic [1:0]  err_code;
  logic        done;

  ejection_sink dut (
    .clk(clk), .rst(rst), .init(init),
    .cfg_router_id(cfg_router_id), .cfg_credit_delay(cfg_credit_delay),
    .cfg_expected_pkts(cfg_expected_pkts), .in_cycle(in_cycle),
    .flit_valid(flit_valid), .flit_vc(flit_vc), .flit_head(flit_head),
    .flit_tail(flit_tail), .flit_dst(flit_dst), .flit_stamp(flit_stamp),
    .cr_valid(cr_valid), .cr_vc(cr_vc), .pkt_count(pkt_count),
    .flit_count(flit_count), .lat_sum(lat_sum), .lat_max(lat_max),
    .err(err), .err_code(err_code), .done(done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int cur_time = 0;

  // Reference model state (spec-level quantities).
  int     m_id, m_d, m_exp;
  int     m_pkts, m_flits, m_lmax, m_code;
  longint m_lsum;
  bit     m_err, m_done;
  bit     m_busy [4];
  int     m_stamp [4];
  int     exp_cr [int];

  // Credit observation bookkeeping for the delay-bound tests.
  int first_cr = -1;
  int last_cr = -1;
  int cr_seen = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int eff_delay(input int d);
    if (d == 0) return 1;
    if (d > 8) return 8;
    return d;
  endfunction

  task automatic model_clear();
    m_pkts = 0; m_flits = 0; m_lsum = 0; m_lmax = 0;
    m_err = 0; m_code = 0; m_done = 0;
    for (int i = 0; i < 4; i++) begin
      m_busy[i] = 0;
      m_stamp[i] = 0;
    end
    exp_cr.delete();
  endtask

  task automatic model_complete(input int lat);
    m_pkts = (m_pkts + 1) % 65536;
    m_lsum = m_lsum + lat;
    if (m_lsum > 64'hFFFF_FFFF) m_lsum = 64'hFFFF_FFFF;
    if (lat > m_lmax) m_lmax = lat;
  endtask

  task automatic model_flit(input int vc, input bit h, input bit t, input int dst, input int stamp);
    int e;
    e = 0;
    m_flits = (m_flits + 1) % 65536;
    exp_cr[cyc + m_d] = vc;
    if (h) begin
      if (m_busy[vc]) e = 1;
      else if (dst != m_id) e = 3;
      if (t) begin
        m_busy[vc] = 0;
        model_complete((cur_time - stamp) & 32'hFFFF);
      end else begin
        m_busy[vc] = 1;
        m_stamp[vc] = stamp;
      end
    end else if (!m_busy[vc]) begin
      e = 2;
    end else if (t) begin
      m_busy[vc] = 0;
      model_complete((cur_time - m_stamp[vc]) & 32'hFFFF);
    end
    if (e != 0) begin
      if (!m_err) m_code = e;
      m_err = 1;
    end
  endtask

  task automatic check_all();
    bit ev;
    ev = exp_cr.exists(cyc);
    chk("cr_valid", 64'(cr_valid), 64'(ev));
    if (ev) begin
      chk("cr_vc", 64'(cr_vc), 64'(exp_cr[cyc]));
      exp_cr.delete(cyc);
    end
    if (cr_valid === 1'b1) begin
      if (first_cr < 0) first_cr = cyc;
      last_cr = cyc;
      cr_seen++;
    end
    chk("pkt_count", 64'(pkt_count), 64'(m_pkts));
    chk("flit_count", 64'(flit_count), 64'(m_flits));
    chk("lat_sum", 64'(lat_sum), 64'(m_lsum));
    chk("lat_max", 64'(lat_max), 64'(m_lmax));
    chk("err", 64'(err), 64'(m_err));
    chk("err_code", 64'(err_code), 64'(m_code));
    chk("done", 64'(done), 64'(m_done));
  endtask

  // One clock: drive inputs, advance the model, clock, check outputs.
  task automatic step(input bit v, input int vc, input bit h, input bit t, input int dst, input int stamp);
    flit_valid = v;
    flit_vc    = 2'(vc);
    flit_head  = h;
    flit_tail  = t;
    flit_dst   = 6'(dst);
    flit_stamp = 16'(stamp);
    in_cycle   = 16'(cur_time);
    if (rst) begin
      model_clear();
      m_id = 0; m_d = 1; m_exp = 0;
    end else if (init) begin
      model_clear();
      m_id = int'(cfg_router_id);
      m_d = eff_delay(int'(cfg_credit_delay));
      m_exp = int'(cfg_expected_pkts);
    end else begin
      if (v) model_flit(vc, h, t, dst, stamp);
      if (m_exp != 0 && m_pkts == m_exp) m_done = 1;
    end
    @(posedge clk);
    #1;
    cyc++;
    cur_time = (cur_time + 1) % 65536;
    check_all();
  endtask

  task automatic flit(input int vc, input bit h, input bit t, input int dst, input int stamp);
    step(1, vc, h, t, dst, stamp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  // The flit offered in the init cycle must be ignored.
  task automatic do_init(input int id, input int d, input int exp);
    cfg_router_id = 6'(id);
    cfg_credit_delay = 4'(d);
    cfg_expected_pkts = 16'(exp);
    init = 1'b1;
    step(1, 1, 1, 1, id, cur_time);
    init = 1'b0;
  endtask

  task automatic do_rst();
    rst = 1'b1;
    step(1, 2, 1, 0, 0, 0);
    rst = 1'b0;
  endtask

  task automatic credit_bound(input int d);
    int c0;
    do_init(5, d, 0);
    first_cr = -1; last_cr = -1; cr_seen = 0;
    c0 = cyc;
    for (int i = 0; i < 4; i++) flit(i, 1, 1, 5, cur_time);
    idle(12);
    chk($sformatf("cr_offset_d%0d", d), 64'(first_cr - c0), 64'(eff_delay(d)));
    chk($sformatf("cr_count_d%0d", d), 64'(cr_seen), 64'd4);
    chk($sformatf("cr_span_d%0d", d), 64'(last_cr - first_cr), 64'd3);
  endtask

  initial begin
    int r, vc, kind, dst, stamp;

    // Reset state
    rst = 1'b1;
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    chk("rst_pkt_count", 64'(pkt_count), 64'd0);
    chk("rst_done", 64'(done), 64'd0);

    // Single packet H/B/T on VC1, D=2
    do_init(5, 2, 1);
    cur_time = 20;
    first_cr = -1; cr_seen = 0;
    flit(1, 1, 0, 5, 10);
    flit(1, 0, 0, 0, 0);
    flit(1, 0, 1, 0, 0);
    chk("single_done", 64'(done), 64'd1);
    chk("single_lat_sum", 64'(lat_sum), 64'd12);
    chk("single_lat_max", 64'(lat_max), 64'd12);
    idle(4);
    chk("single_cr_count", 64'(cr_seen), 64'd3);

    // Interleaved VCs
    do_init(5, 3, 0);
    cur_time = 100;
    flit(0, 1, 0, 5, 90);
    flit(2, 1, 0, 5, 70);
    flit(0, 0, 0, 0, 0);
    flit(2, 0, 1, 0, 0);
    flit(0, 0, 1, 0, 0);
    chk("ilv_pkts", 64'(pkt_count), 64'd2);
    chk("ilv_err", 64'(err), 64'd0);
    chk("ilv_lat_max", 64'(lat_max), 64'd33);
    idle(4);

    // Head on busy VC
    do_init(5, 1, 0);
    flit(3, 1, 0, 5, cur_time);
    flit(3, 0, 0, 0, 0);
    flit(3, 1, 0, 5, cur_time);
    flit(3, 0, 1, 0, 0);
    chk("hb_err", 64'(err), 64'd1);
    chk("hb_code", 64'(err_code), 64'd1);
    chk("hb_pkts", 64'(pkt_count), 64'd1);
    chk("hb_flits", 64'(flit_count), 64'd4);
    idle(2);

    // Error ordering: orphan then destination mismatch
    do_init(5, 1, 0);
    flit(0, 0, 1, 0, 0);
    chk("ord_code_first", 64'(err_code), 64'd2);
    flit(1, 1, 1, 7, cur_time);
    chk("ord_code_kept", 64'(err_code), 64'd2);
    chk("ord_pkts", 64'(pkt_count), 64'd1);
    idle(2);

    // Credit delay bounds
    credit_bound(1);
    credit_bound(8);
    credit_bound(0);
    credit_bound(12);

    // Reset with credits pending
    do_init(5, 8, 0);
    flit(0, 1, 0, 5, cur_time);
    flit(0, 0, 0, 0, 0);
    flit(1, 1, 1, 5, cur_time);
    idle(2);
    do_rst();
    cr_seen = 0;
    idle(12);
    chk("rst_mid_no_credit", 64'(cr_seen), 64'd0);
    chk("rst_mid_flits", 64'(flit_count), 64'd0);

    // Stamp wrap: 0xFFFE -> 0x0003 gives latency 5
    do_init(5, 1, 0);
    cur_time = 16'hFFF0;
    flit(2, 1, 0, 5, 16'hFFFE);
    cur_time = 3;
    flit(2, 0, 1, 0, 0);
    chk("wrap_lat_max", 64'(lat_max), 64'd5);
    chk("wrap_lat_sum", 64'(lat_sum), 64'd5);
    idle(2);

    // Randomized traffic against the model
    do_init(5, $urandom_range(0, 12), $urandom_range(1, 30));
    for (int n = 0; n < 500; n++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        do_init($urandom_range(0, 63), $urandom_range(0, 12), $urandom_range(0, 30));
      end else if (r < 70) begin
        vc = $urandom_range(0, 3);
        kind = $urandom_range(0, 9);
        dst = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 63) : m_id;
        stamp = (cur_time - $urandom_range(0, 40)) & 32'hFFFF;
        if (kind < 3)      flit(vc, 1, 0, dst, stamp);
        else if (kind < 5) flit(vc, 1, 1, dst, stamp);
        else if (kind < 7) flit(vc, 0, 0, dst, stamp);
        else               flit(vc, 0, 1, dst, stamp);
      end else begin
        idle(1);
      end
    end
    idle(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
